debounce_edge: RTL and testbench

- Conditioning stage directly downstream of the `ffd` D flip-flop; consumes its registered output `q` on `d_in`.
- Re-synchronises `d_in`, then debounces it: a change is accepted only after STABLE_CYCLES consecutive enabled samples at the new value.
- Outputs are a clean level plus single-cycle rise/fall pulses, consumed by control logic that must not see glitches.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/sync_chain.sv | 25 ++
 rtl/debounce_edge.sv | 100 ++++++++++
 tb/tb_debounce_edge.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_edge conditioning stage.
// Provides the FSM state encoding and the counter-width calculation.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        PEND_LOW    = 2'b11
    } deb_state_t;

    // Width needed to hold counts 0..stable inclusive.
    function automatic int cnt_w(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Synchroniser flop chain; shifts every cycle.
// Ports: aclk clock, srst sync reset (active-high), d async-ish input, q last stage.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic aclk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_q;

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_q <= {STAGES{RESET_VAL}};
        end else begin
            r_q <= {r_q[STAGES-2:0], d};
        end
    end

    assign q = r_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with registered level and single-cycle rise/fall pulses.
// Ports: aclk, srst (sync, active-high), d_in raw level, en sample tick,
//        level_o debounced level, rise_o/fall_o edge pulses, busy_o change pending.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 8,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic aclk,
    input  logic srst,
    input  logic d_in,
    input  logic en,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CNT_W = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic ONE_SHOT = (STABLE_CYCLES == 1);

    logic             w_s;
    logic             w_diff;
    logic             w_pend;
    logic             w_commit;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .aclk (aclk),
        .srst (srst),
        .d    (d_in),
        .q    (w_s)
    );

    assign w_diff = (w_s != r_level);
    assign w_pend = (r_state == PEND_HIGH) || (r_state == PEND_LOW);

    // A change is accepted on the enabled sample that completes the run;
    // with a single-sample requirement a stable state commits directly.
    assign w_commit = en && w_diff && (w_pend ? (r_cnt == LAST) : ONE_SHOT);

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_commit) begin
                r_level <= ~r_level;
                r_rise  <= ~r_level;
                r_fall  <= r_level;
                r_state <= r_level ? STABLE_LOW : STABLE_HIGH;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else if (en) begin
                unique case (r_state)
                    STABLE_LOW, STABLE_HIGH: begin
                        if (w_diff) begin
                            r_state <= r_level ? PEND_LOW : PEND_HIGH;
                            r_cnt   <= CNT_W'(1);
                            r_busy  <= 1'b1;
                        end
                    end
                    PEND_HIGH, PEND_LOW: begin
                        if (!w_diff) begin
                            // Glitch ended before the run completed.
                            r_state <= r_level ? STABLE_HIGH : STABLE_LOW;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: stimulus pushes the hand-computed
// {level,rise,fall,busy} expected after each edge; a monitor pops and compares.
module tb_debounce_edge;

    logic aclk;
    logic srst;
    logic d_in;
    logic en;
    logic level_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    logic [3:0] sb[$];
    int n_vec;
    int n_err;

    debounce_edge #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .aclk    (aclk),
        .srst    (srst),
        .d_in    (d_in),
        .en      (en),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .busy_o  (busy_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Monitor: one expectation per edge, compared 1 time unit after it.
    always @(posedge aclk) begin
        logic [3:0] exp;
        logic [3:0] act;
        #1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            act = {level_o, rise_o, fall_o, busy_o};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL vec%0d {lvl,rise,fall,busy} got %b want %b @%0t",
                         n_vec, act, exp, $time);
            end
        end
    end

    // Drive inputs for one edge and record what must appear after it.
    task automatic step(input logic d, input logic e, input logic r,
                        input logic [3:0] exp);
        d_in = d;
        en   = e;
        srst = r;
        sb.push_back(exp);
        @(posedge aclk);
        #3;
    endtask

    // d_in switches to newd at m=0 and is held; commit lands 9 edges later.
    task automatic run_change(input logic newd, input int n);
        logic old;
        old = ~newd;
        for (int m = 0; m < n; m++) begin
            if (m < 2)
                step(newd, 1'b1, 1'b0, {old, 3'b000});
            else if (m < 9)
                step(newd, 1'b1, 1'b0, {old, 3'b001});
            else if (m == 9)
                step(newd, 1'b1, 1'b0, {newd, newd, old, 1'b0});
            else
                step(newd, 1'b1, 1'b0, {newd, 3'b000});
        end
    endtask

    // High pulse of h samples, then low; never long enough to commit.
    task automatic glitch(input int h);
        for (int m = 0; m < h + 4; m++) begin
            step(m < h, 1'b1, 1'b0, {3'b000, (m >= 2 && m <= h + 1)});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        d_in  = 1'b1;
        en    = 1'b1;
        srst  = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'b0000);

        glitch(3);
        glitch(7);

        run_change(1'b1, 12);
        run_change(1'b0, 12);

        // en every 4th cycle: pend at edge 4, commit on the 8th tick (edge 32).
        for (int m = 0; m < 36; m++) begin
            if (m < 4)
                step(1'b1, (m % 4) == 0, 1'b0, 4'b0000);
            else if (m < 32)
                step(1'b1, (m % 4) == 0, 1'b0, 4'b0001);
            else if (m == 32)
                step(1'b1, 1'b1, 1'b0, 4'b1100);
            else
                step(1'b1, (m % 4) == 0, 1'b0, 4'b1000);
        end

        run_change(1'b0, 12);

        // Counter reaches 5 after m=6; reset then hits a pending change.
        for (int m = 0; m < 7; m++) begin
            step(1'b1, 1'b1, 1'b0, (m < 2) ? 4'b0000 : 4'b0001);
        end
        step(1'b1, 1'b1, 1'b1, 4'b0000);
        run_change(1'b1, 12);

        @(posedge aclk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain left %0d want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
